// File: rtl/atomic_bus_initiator.sv
// Wishbone initiator for loads, stores, lr.w/sc.w and RV32A AMOs.
// Drives LOCK/UNLOCK address tags so the responder's reservation logic sees them in order.
module atomic_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  input  logic [3:0]  req_sel_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic [3:0]  sel_o,
  output logic [2:0]  addr_tag_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic [31:0] data_i,
  input  logic        data_tag_i
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LR    = 4'd2;
  localparam logic [3:0] OP_SC    = 4'd3;
  localparam logic [3:0] OP_SWAP  = 4'd4;
  localparam logic [3:0] OP_ADD   = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_MIN   = 4'd9;
  localparam logic [3:0] OP_MAX   = 4'd10;
  localparam logic [3:0] OP_MINU  = 4'd11;
  localparam logic [3:0] OP_MAXU  = 4'd12;

  localparam logic [1:0] ADDR_TAG_MODE_NONE = 2'd0;
  localparam logic [1:0] ADDR_TAG_MODE_LRSC = 2'd1;
  localparam logic [1:0] ADDR_TAG_MODE_AMO  = 2'd2;
  localparam logic       ADDR_TAG_LOCK      = 1'b1;
  localparam logic       ADDR_TAG_UNLOCK    = 1'b0;

  localparam logic [2:0] TAG_NONE     = {ADDR_TAG_MODE_NONE, ADDR_TAG_UNLOCK};
  localparam logic [2:0] TAG_LR       = {ADDR_TAG_MODE_LRSC, ADDR_TAG_LOCK};
  localparam logic [2:0] TAG_SC       = {ADDR_TAG_MODE_LRSC, ADDR_TAG_UNLOCK};
  localparam logic [2:0] TAG_AMO_RD   = {ADDR_TAG_MODE_AMO, ADDR_TAG_LOCK};
  localparam logic [2:0] TAG_AMO_WR   = {ADDR_TAG_MODE_AMO, ADDR_TAG_UNLOCK};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]       r_state, w_state_nxt;
  logic [3:0]       r_op, w_op_nxt;
  logic [31:0]      r_operand, w_operand_nxt;
  logic [31:0]      r_old, w_old_nxt;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]      r_rsp_data, w_rsp_data_nxt;
  logic             r_rsp_err, w_rsp_err_nxt;
  logic             r_cyc, w_cyc_nxt;
  logic             r_stb, w_stb_nxt;
  logic             r_we, w_we_nxt;
  logic [31:0]      r_addr, w_addr_nxt;
  logic [31:0]      r_data, w_data_nxt;
  logic [3:0]       r_sel, w_sel_nxt;
  logic [2:0]       r_tag, w_tag_nxt;

  logic        w_req_amo, w_req_atomic, w_req_illegal, w_req_misal, w_req_reads;
  logic        w_op_amo, w_abort;
  logic [31:0] w_amo_result;

  assign w_req_amo     = (req_op_i >= OP_SWAP) && (req_op_i <= OP_MAXU);
  assign w_req_atomic  = w_req_amo || (req_op_i == OP_LR) || (req_op_i == OP_SC);
  assign w_req_illegal = req_op_i > OP_MAXU;
  assign w_req_misal   = (req_addr_i[1:0] != 2'b00) || (req_sel_i != 4'hF);
  assign w_req_reads   = (req_op_i == OP_LOAD) || (req_op_i == OP_LR) || w_req_amo;
  assign w_op_amo      = r_op >= OP_SWAP;
  // err_i beats ack_i; a timeout only fires when the responder has not just acked
  assign w_abort       = err_i || (!ack_i && (r_tmo_cnt == TMO_LAST));

  // AMO new-value datapath, evaluated during CALC
  always_comb begin
    w_amo_result = r_operand;
    case (r_op)
      OP_ADD:  w_amo_result = r_old + r_operand;
      OP_XOR:  w_amo_result = r_old ^ r_operand;
      OP_AND:  w_amo_result = r_old & r_operand;
      OP_OR:   w_amo_result = r_old | r_operand;
      OP_MIN:  w_amo_result = ($signed(r_old) < $signed(r_operand)) ? r_old : r_operand;
      OP_MAX:  w_amo_result = ($signed(r_old) > $signed(r_operand)) ? r_old : r_operand;
      OP_MINU: w_amo_result = (r_old < r_operand) ? r_old : r_operand;
      OP_MAXU: w_amo_result = (r_old > r_operand) ? r_old : r_operand;
      default: w_amo_result = r_operand;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_operand_nxt   = r_operand;
    w_old_nxt       = r_old;
    w_tmo_nxt       = r_tmo_cnt;
    w_ready_nxt     = r_ready;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_cyc_nxt       = r_cyc;
    w_stb_nxt       = r_stb;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_sel_nxt       = r_sel;
    w_tag_nxt       = r_tag;

    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_op_nxt      = req_op_i;
          w_operand_nxt = req_data_i;
          w_ready_nxt   = 1'b0;
          if (w_req_illegal || (w_req_atomic && w_req_misal)) begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_data_nxt  = 32'd0;
          end else begin
            w_addr_nxt = req_addr_i;
            w_sel_nxt  = req_sel_i;
            w_cyc_nxt  = 1'b1;
            w_stb_nxt  = 1'b1;
            w_tmo_nxt  = '0;
            if (w_req_reads) begin
              w_state_nxt = S_READ;
              w_we_nxt    = 1'b0;
              w_data_nxt  = 32'd0;
              w_tag_nxt   = (req_op_i == OP_LOAD) ? TAG_NONE :
                            (req_op_i == OP_LR)   ? TAG_LR : TAG_AMO_RD;
            end else begin
              w_state_nxt = S_WRITE;
              w_we_nxt    = 1'b1;
              w_data_nxt  = req_data_i;
              w_tag_nxt   = (req_op_i == OP_SC) ? TAG_SC : TAG_NONE;
            end
          end
        end
      end

      S_READ: begin
        if (w_abort) begin
          w_cyc_nxt       = 1'b0;
          w_stb_nxt       = 1'b0;
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_data_nxt  = 32'd0;
        end else if (ack_i) begin
          w_stb_nxt = 1'b0;
          w_old_nxt = data_i;
          if (w_op_amo) begin
            w_state_nxt = S_CALC;
          end else begin
            w_cyc_nxt       = 1'b0;
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b0;
            w_rsp_data_nxt  = data_i;
          end
        end else begin
          w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
        end
      end

      // cyc_o stays high across CALC so the reservation is not released
      S_CALC: begin
        w_data_nxt  = w_amo_result;
        w_we_nxt    = 1'b1;
        w_stb_nxt   = 1'b1;
        w_tag_nxt   = TAG_AMO_WR;
        w_tmo_nxt   = '0;
        w_state_nxt = S_WRITE;
      end

      S_WRITE: begin
        if (w_abort) begin
          w_cyc_nxt       = 1'b0;
          w_stb_nxt       = 1'b0;
          w_we_nxt        = 1'b0;
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_data_nxt  = 32'd0;
        end else if (ack_i) begin
          w_cyc_nxt       = 1'b0;
          w_stb_nxt       = 1'b0;
          w_we_nxt        = 1'b0;
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_data_nxt  = (r_op == OP_SC)    ? {31'd0, data_tag_i} :
                            (r_op == OP_STORE) ? 32'd0 : r_old;
        end else begin
          w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
        end
      end

      S_RESP: begin
        w_ready_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
        w_cyc_nxt   = 1'b0;
        w_stb_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_op        <= OP_LOAD;
      r_operand   <= 32'd0;
      r_old       <= 32'd0;
      r_tmo_cnt   <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_data      <= 32'd0;
      r_sel       <= 4'd0;
      r_tag       <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_operand   <= w_operand_nxt;
      r_old       <= w_old_nxt;
      r_tmo_cnt   <= w_tmo_nxt;
      r_ready     <= w_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_cyc       <= w_cyc_nxt;
      r_stb       <= w_stb_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_sel       <= w_sel_nxt;
      r_tag       <= w_tag_nxt;
    end
  end

  assign req_ready_o = r_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;
  assign cyc_o       = r_cyc;
  assign stb_o       = r_stb;
  assign we_o        = r_we;
  assign addr_o      = r_addr;
  assign data_o      = r_data;
  assign sel_o       = r_sel;
  assign addr_tag_o  = r_tag;

endmodule

// File: tb/tb_atomic_bus_initiator.sv
// Self-checking bench: directed scenarios plus random requests against a word-memory responder
// and a transaction-level reference model of the expected responses and bus writes.
module tb_atomic_bus_initiator;

  localparam logic [2:0] T_NONE   = 3'b000;
  localparam logic [2:0] T_LR     = 3'b011;
  localparam logic [2:0] T_SC     = 3'b010;
  localparam logic [2:0] T_AMO_RD = 3'b101;
  localparam logic [2:0] T_AMO_WR = 3'b100;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_data = 32'd0;
  logic [3:0]  req_sel = 4'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [31:0] addr, dat_o;
  logic [3:0]  sel;
  logic [2:0]  tag;
  logic        ack = 1'b0;
  logic        err = 1'b0;
  logic [31:0] dat_i = 32'd0;
  logic        dtag = 1'b0;

  atomic_bus_initiator #(.TIMEOUT_CYCLES(15)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_i(req), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .addr_o(addr), .data_o(dat_o), .sel_o(sel),
    .addr_tag_o(tag), .ack_i(ack), .err_i(err), .data_i(dat_i), .data_tag_i(dtag)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // responder controls (written by the main sequence only)
  int          rsp_wait = 0;
  bit          rsp_noack = 1'b0;
  bit          rsp_err_inj = 1'b0;
  bit          rsp_sctag = 1'b0;
  bit          poke_en = 1'b0;
  logic [7:0]  poke_idx = 8'd0;
  logic [31:0] poke_val = 32'd0;

  // responder state and observations
  logic [31:0] mem [0:255];
  int          wcnt = 0;
  int          rd_n = 0;
  int          wr_n = 0;
  logic [2:0]  rd_tag = 3'd0;
  logic [2:0]  wr_tag = 3'd0;
  logic [31:0] wr_data = 32'd0;

  always @(posedge clk) begin
    ack <= 1'b0;
    err <= 1'b0;
    if (poke_en) mem[poke_idx] <= poke_val;
    if (cyc && stb && !ack && !err && !rsp_noack) begin
      if (wcnt >= rsp_wait) begin
        wcnt <= 0;
        if (rsp_err_inj) begin
          err <= 1'b1;
        end else begin
          ack  <= 1'b1;
          dtag <= rsp_sctag;
          if (we) begin
            wr_n    <= wr_n + 1;
            wr_tag  <= tag;
            wr_data <= dat_o;
            if (!(tag == T_SC && rsp_sctag)) mem[addr[9:2]] <= dat_o;
          end else begin
            rd_n   <= rd_n + 1;
            rd_tag <= tag;
            dat_i  <= mem[addr[9:2]];
          end
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else if (!(cyc && stb)) begin
      wcnt <= 0;
    end
  end

  // bus monitor, sampled on the falling edge
  int          rsp_pulses = 0;
  int          cyc_seen = 0;
  int          gap_cnt = 0;
  int          stb_hi = 0;
  int          stb_rises = 0;
  int          stab_viol = 0;
  logic        p_stb = 1'b0;
  logic [71:0] p_bus = '0;

  always @(negedge clk) begin
    if (rsp_valid) rsp_pulses <= rsp_pulses + 1;
    if (cyc) cyc_seen <= cyc_seen + 1;
    if (cyc && !stb) gap_cnt <= gap_cnt + 1;
    if (stb) stb_hi <= stb_hi + 1;
    if (stb && !p_stb) stb_rises <= stb_rises + 1;
    if (stb && p_stb && ({addr, dat_o, sel, we, tag} != p_bus)) stab_viol <= stab_viol + 1;
    p_stb <= stb;
    p_bus <= {addr, dat_o, sel, we, tag};
  end

  logic [31:0] exp_mem [0:255];
  logic [31:0] r_data;
  logic        r_err;
  bit          got;

  task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", nm, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = 8'(idx);
    poke_val = v;
    exp_mem[idx] = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  function automatic logic [31:0] amo_ref(input logic [3:0] op, input logic [31:0] o, input logic [31:0] b);
    int     so, sb;
    longint uo, ub;
    so = o;
    sb = b;
    uo = {32'd0, o};
    ub = {32'd0, b};
    case (op)
      4'd4:    return b;
      4'd5:    return 32'(uo + ub);
      4'd6:    return o ^ b;
      4'd7:    return o & b;
      4'd8:    return o | b;
      4'd9:    return (so <= sb) ? o : b;
      4'd10:   return (so >= sb) ? o : b;
      4'd11:   return (uo <= ub) ? o : b;
      default: return (uo >= ub) ? o : b;
    endcase
  endfunction

  task automatic do_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    int n;
    @(negedge clk);
    req = 1'b1; req_op = op; req_addr = a; req_data = d; req_sel = s;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req = 1'b0;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      if (rsp_valid) begin
        got = 1'b1;
        r_data = rsp_data;
        r_err = rsp_err;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    check("rsp_seen", 32'(got), 32'd1);
    @(negedge clk);
  endtask

  task automatic txn(input string nm, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input bit sct);
    int rd0, wr0, pl0, cy0, gp0;
    logic [31:0] old_v, new_v;
    bit amo, bad;
    rd0 = rd_n; wr0 = wr_n; pl0 = rsp_pulses; cy0 = cyc_seen; gp0 = gap_cnt;
    rsp_sctag = sct;
    old_v = exp_mem[a[9:2]];
    amo = (op >= 4'd4) && (op <= 4'd12);
    bad = (op > 4'd12) || ((amo || op == 4'd2 || op == 4'd3) && (a[1:0] != 2'b00 || s != 4'hF));
    do_req(op, a, d, s);
    check({nm, ":err"}, 32'(r_err), 32'(bad));
    check({nm, ":pulses"}, 32'(rsp_pulses - pl0), 32'd1);
    if (bad) begin
      check({nm, ":no_cyc"}, 32'(cyc_seen - cy0), 32'd0);
    end else begin
      check({nm, ":calc_gap"}, 32'(gap_cnt - gp0), amo ? 32'd1 : 32'd0);
      if (op == 4'd0 || op == 4'd2) begin
        check({nm, ":data"}, r_data, old_v);
        check({nm, ":reads"}, 32'(rd_n - rd0), 32'd1);
        check({nm, ":writes"}, 32'(wr_n - wr0), 32'd0);
        check({nm, ":rd_tag"}, 32'(rd_tag), 32'(op == 4'd2 ? T_LR : T_NONE));
      end else if (op == 4'd1 || op == 4'd3) begin
        check({nm, ":data"}, r_data, (op == 4'd3) ? 32'(sct) : 32'd0);
        check({nm, ":reads"}, 32'(rd_n - rd0), 32'd0);
        check({nm, ":writes"}, 32'(wr_n - wr0), 32'd1);
        check({nm, ":wr_tag"}, 32'(wr_tag), 32'(op == 4'd3 ? T_SC : T_NONE));
        check({nm, ":wr_data"}, wr_data, d);
        if (!(op == 4'd3 && sct)) exp_mem[a[9:2]] = d;
      end else begin
        new_v = amo_ref(op, old_v, d);
        check({nm, ":data"}, r_data, old_v);
        check({nm, ":reads"}, 32'(rd_n - rd0), 32'd1);
        check({nm, ":writes"}, 32'(wr_n - wr0), 32'd1);
        check({nm, ":rd_tag"}, 32'(rd_tag), 32'(T_AMO_RD));
        check({nm, ":wr_tag"}, 32'(wr_tag), 32'(T_AMO_WR));
        check({nm, ":wr_data"}, wr_data, new_v);
        exp_mem[a[9:2]] = new_v;
      end
    end
    rsp_sctag = 1'b0;
  endtask

  initial begin
    int rd0, wr0, pl0, sr0, sh0, n;
    logic [3:0]  op;
    logic [31:0] a;
    logic [3:0]  s;

    for (int i = 0; i < 256; i++) exp_mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("reset:ready", 32'(req_ready), 32'd1);
    check("reset:cyc_stb_we", {29'd0, cyc, stb, we}, 32'd0);
    check("reset:rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check("reset:rsp_data", rsp_data, 32'd0);
    check("reset:tag", 32'(tag), 32'd0);

    for (int i = 0; i < 256; i++) poke(i, 32'd0);

    // load with two wait states
    rsp_wait = 2;
    poke(0, 32'hDEAD_BEEF);
    txn("load", 4'd0, 32'h0000_1000, 32'd0, 4'hF, 1'b0);
    rsp_wait = 0;

    // lr/sc pair, then sc success and failure
    poke(32'h40, 32'h1234_5678);
    txn("lr", 4'd2, 32'h100, 32'd0, 4'hF, 1'b0);
    txn("sc_ok", 4'd3, 32'h100, 32'd5, 4'hF, 1'b0);
    txn("lr2", 4'd2, 32'h100, 32'd0, 4'hF, 1'b0);
    txn("sc_fail", 4'd3, 32'h100, 32'd5, 4'hF, 1'b1);

    // amo add wrap, signed and unsigned min
    poke(32'h80, 32'hFFFF_FFFF);
    txn("amoadd", 4'd5, 32'h200, 32'd2, 4'hF, 1'b0);
    check("amoadd:wrapped", wr_data, 32'h0000_0001);
    poke(32'hC0, 32'h8000_0000);
    txn("amomin", 4'd9, 32'h300, 32'd1, 4'hF, 1'b0);
    check("amomin:value", wr_data, 32'h8000_0000);
    poke(32'hC0, 32'h8000_0000);
    txn("amominu", 4'd11, 32'h300, 32'd1, 4'hF, 1'b0);
    check("amominu:value", wr_data, 32'h0000_0001);

    // amo read never acked: timeout, no write phase
    rsp_noack = 1'b1;
    rd0 = rd_n; wr0 = wr_n; sr0 = stb_rises; sh0 = stb_hi;
    do_req(4'd5, 32'h200, 32'd7, 4'hF);
    rsp_noack = 1'b0;
    check("tmo:err", 32'(r_err), 32'd1);
    check("tmo:no_write", 32'(wr_n - wr0), 32'd0);
    check("tmo:one_strobe", 32'(stb_rises - sr0), 32'd1);
    check("tmo:len_ok", 32'((stb_hi - sh0) >= 15 && (stb_hi - sh0) <= 17), 32'd1);

    // amo read answered with err_i: no write phase
    rsp_err_inj = 1'b1;
    wr0 = wr_n; sr0 = stb_rises;
    do_req(4'd4, 32'h200, 32'd9, 4'hF);
    rsp_err_inj = 1'b0;
    check("rderr:err", 32'(r_err), 32'd1);
    check("rderr:one_strobe", 32'(stb_rises - sr0), 32'd1);
    check("rderr:no_write", 32'(wr_n - wr0), 32'd0);

    // misaligned sc and illegal op
    txn("sc_misal", 4'd3, 32'h102, 32'd5, 4'hF, 1'b0);
    txn("illegal", 4'd14, 32'h100, 32'd5, 4'hF, 1'b0);

    // reset during the write phase
    rsp_noack = 1'b1;
    pl0 = rsp_pulses;
    @(negedge clk);
    req = 1'b1; req_op = 4'd1; req_addr = 32'h44; req_data = 32'hA5A5_5A5A; req_sel = 4'hF;
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (!(stb && we) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstw:in_write", 32'(stb && we), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rstw:cyc_stb_drop", {30'd0, cyc, stb}, 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    rsp_noack = 1'b0;
    @(negedge clk);
    check("rstw:ready", 32'(req_ready), 32'd1);
    check("rstw:no_rsp", 32'(rsp_pulses - pl0), 32'd0);
    txn("post_rst_load", 4'd0, 32'h44, 32'd0, 4'hF, 1'b0);

    // random requests against the reference model
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    for (int i = 0; i < 80; i++) begin
      rsp_wait = $urandom_range(0, 3);
      op = 4'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(13, 15));
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      s = 4'hF;
      if ($urandom_range(0, 7) == 0) s = 4'($urandom_range(0, 14));
      txn("rand", op, a, $urandom, s, 1'($urandom_range(0, 1)));
    end

    check("bus_stable_while_stb", 32'(stab_viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
